// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the RV32M iterative multiply/divide
// sequencer.
//   state_t       FSM states of muldiv_sequencer
//   OP_*          funct3 encodings of the M-extension operations
//   is_div()      operation belongs to the divide/remainder group
//   a_signed()    operand A is interpreted as two's complement
//   b_signed()    operand B is interpreted as two's complement
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: datapath registers for a 1-bit-per-cycle unsigned
// shift-add multiply and restoring shift-subtract divide.
//   clk        clock
//   rst_n      synchronous active-low reset, clears all registers
//   load       load operand magnitudes (multiplier/dividend and
//              multiplicand/divisor) and clear the partial results
//   step       perform one iteration in the selected mode
//   mode_div   0: multiply, 1: divide
//   a_mag      magnitude of operand A
//   b_mag      magnitude of operand B
//   product    2*XLEN-bit unsigned product (valid after XLEN steps)
//   quotient   unsigned quotient (valid after XLEN steps)
//   remainder  unsigned remainder (valid after XLEN steps)
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic                mode_div,
    input  logic [XLEN-1:0]     a_mag,
    input  logic [XLEN-1:0]     b_mag,
    output logic [2*XLEN-1:0]   product,
    output logic [XLEN-1:0]     quotient,
    output logic [XLEN-1:0]     remainder
);

    // Multiply: low half of prod_reg starts as the multiplier and is shifted
    // out LSB-first while the upper half accumulates. opnd_reg holds the
    // multiplicand for multiply and the divisor for divide.
    logic [2*XLEN-1:0] prod_reg;
    logic [XLEN-1:0]   quo_reg;
    logic [XLEN:0]     rem_reg;
    logic [XLEN-1:0]   opnd_reg;

    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shifted;
    logic [XLEN+1:0]   div_trial;

    always_comb begin
        mul_sum     = {1'b0, prod_reg[2*XLEN-1:XLEN]}
                    + (prod_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
        // Bring the next dividend bit into the partial remainder; the extra
        // top bit makes the trial subtract's sign bit a clean borrow flag.
        div_shifted = {rem_reg, quo_reg[XLEN-1]};
        div_trial   = div_shifted - {2'b00, opnd_reg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_reg <= '0;
            quo_reg  <= '0;
            rem_reg  <= '0;
            opnd_reg <= '0;
        end else if (load) begin
            prod_reg <= {{XLEN{1'b0}}, mode_div ? a_mag : b_mag};
            quo_reg  <= a_mag;
            rem_reg  <= '0;
            opnd_reg <= mode_div ? b_mag : a_mag;
        end else if (step) begin
            if (mode_div) begin
                if (!div_trial[XLEN+1]) begin
                    rem_reg <= div_trial[XLEN:0];
                    quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
                end else begin
                    rem_reg <= div_shifted[XLEN:0];
                    quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
                end
            end else begin
                prod_reg <= {mul_sum, prod_reg[XLEN-1:1]};
            end
        end
    end

    assign product   = prod_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg[XLEN-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide controller.
// Accepts one operation in IDLE, runs XLEN iterations on operand magnitudes,
// sign-corrects, and presents the result with its destination tag.
//   iClk     clock
//   iRstN    synchronous active-low reset
//   iStart   request a new operation (sampled only in IDLE)
//   iFunct3  M-extension operation select
//   iRs1     operand A (multiplicand / dividend)
//   iRs2     operand B (multiplier / divisor)
//   iRd      destination register tag
//   iFlush   abort the operation in flight
//   oBusy    high whenever not IDLE (decode stall)
//   oValid   one-cycle pulse, oResult/oRd valid
//   oResult  final result, held until the next completion
//   oRd      destination tag of the completed operation
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iStart,
    input  logic [2:0]      iFunct3,
    input  logic [XLEN-1:0] iRs1,
    input  logic [XLEN-1:0] iRs2,
    input  logic [4:0]      iRd,
    input  logic            iFlush,
    output logic            oBusy,
    output logic            oValid,
    output logic [XLEN-1:0] oResult,
    output logic [4:0]      oRd
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   rs1_reg, rs2_reg;
    logic [4:0]        rd_reg;
    logic              a_neg_reg, b_neg_reg;
    logic [CW-1:0]     cnt_reg;
    logic [XLEN-1:0]   res_reg;
    logic              valid_reg;
    logic [XLEN-1:0]   result_out_reg;
    logic [4:0]        rd_out_reg;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_by_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] product, prod_fix;
    logic [XLEN-1:0]   quotient, remainder, quo_fix, rem_fix, fix_res;

    // Operand sign/magnitude and divide special cases, evaluated in PREP.
    // The magnitude of INT_MIN wraps to itself, which is correct when the
    // result is treated as unsigned.
    always_comb begin
        a_neg       = a_signed(op_reg) && rs1_reg[XLEN-1];
        b_neg       = b_signed(op_reg) && rs2_reg[XLEN-1];
        a_mag       = a_neg ? -rs1_reg : rs1_reg;
        b_mag       = b_neg ? -rs2_reg : rs2_reg;
        div_by_zero = is_div(op_reg) && (rs2_reg == '0);
        div_ovf     = ((op_reg == OP_DIV) || (op_reg == OP_REM))
                    && (rs1_reg == INT_MIN) && (rs2_reg == '1);
        special     = div_by_zero || div_ovf;
        // op_reg[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_by_zero) begin
            special_res = op_reg[1] ? rs1_reg : '1;
        end else begin
            special_res = op_reg[1] ? '0 : INT_MIN;
        end
    end

    // Sign correction applied in FIX.
    always_comb begin
        prod_fix = (a_neg_reg ^ b_neg_reg) ? -product : product;
        quo_fix  = (a_neg_reg ^ b_neg_reg) ? -quotient : quotient;
        rem_fix  = a_neg_reg ? -remainder : remainder;
        fix_res  = '0;
        if (is_div(op_reg)) begin
            fix_res = op_reg[1] ? rem_fix : quo_fix;
        end else if (op_reg == OP_MUL) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (iClk),
        .rst_n     (iRstN),
        .load      (state_reg == ST_PREP),
        .step      (state_reg == ST_CALC),
        .mode_div  (is_div(op_reg)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Flush overrides every transition out of a busy state.
    always_comb begin
        state_next = state_reg;
        if (iFlush && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (iStart && !iFlush) state_next = ST_PREP;
                ST_PREP: state_next = special ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_reg == CNT_LAST) state_next = ST_FIX;
                ST_FIX:  state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // The output registers are only written when DONE completes unflushed,
    // so oValid appears the cycle after DONE and a flush leaves oResult alone.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            op_reg         <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            rd_reg         <= '0;
            a_neg_reg      <= 1'b0;
            b_neg_reg      <= 1'b0;
            cnt_reg        <= '0;
            res_reg        <= '0;
            valid_reg      <= 1'b0;
            result_out_reg <= '0;
            rd_out_reg     <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (iStart && !iFlush) begin
                        op_reg  <= iFunct3;
                        rs1_reg <= iRs1;
                        rs2_reg <= iRs2;
                        rd_reg  <= iRd;
                    end
                end
                ST_PREP: begin
                    a_neg_reg <= a_neg;
                    b_neg_reg <= b_neg;
                    cnt_reg   <= '0;
                    if (special) res_reg <= special_res;
                end
                ST_CALC: cnt_reg <= cnt_reg + 1'b1;
                ST_FIX:  res_reg <= fix_res;
                ST_DONE: begin
                    if (!iFlush) begin
                        valid_reg      <= 1'b1;
                        result_out_reg <= res_reg;
                        rd_out_reg     <= rd_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy   = (state_reg != ST_IDLE);
    assign oValid  = valid_reg;
    assign oResult = result_out_reg;
    assign oRd     = rd_out_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iStart;
    logic [2:0]  iFunct3;
    logic [31:0] iRs1, iRs2;
    logic [4:0]  iRd;
    logic        iFlush;
    logic        oBusy, oValid;
    logic [31:0] oResult;
    logic [4:0]  oRd;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iStart  (iStart),
        .iFunct3 (iFunct3),
        .iRs1    (iRs1),
        .iRs2    (iRs2),
        .iRd     (iRd),
        .iFlush  (iFlush),
        .oBusy   (oBusy),
        .oValid  (oValid),
        .oResult (oResult),
        .oRd     (oRd)
    );

    always #5 iClk = ~iClk;

    // Reference: RV32M semantics computed with 64-bit native arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    // Cycles from accept edge to the oValid cycle.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Issue one operation from IDLE and check result, tag, latency, busy span.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        logic [31:0] exp_res;
        int          exp_lat, lat, busy_cnt;
        exp_res = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        @(negedge iClk);
        iStart = 1'b1; iFunct3 = f3; iRs1 = a; iRs2 = b; iRd = rd;
        @(negedge iClk);
        iStart = 1'b0; iRd = ~rd; iRs1 = $urandom; iRs2 = $urandom;
        busy_cnt = oBusy ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge iClk);
            if (oValid) begin lat = k; break; end
            if (oBusy) busy_cnt++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL latency f3=%0d a=%h b=%h: got %0d expected %0d", f3, a, b, lat, exp_lat);
        end
        checks++;
        if (busy_cnt !== exp_lat) begin
            errors++;
            $display("FAIL busy_span f3=%0d: got %0d expected %0d", f3, busy_cnt, exp_lat);
        end
        checks++;
        if (oResult !== exp_res) begin
            errors++;
            $display("FAIL result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, oResult, exp_res);
        end
        checks++;
        if (oRd !== rd) begin
            errors++;
            $display("FAIL rd f3=%0d: got %0d expected %0d", f3, oRd, rd);
        end
        $display("op f3=%0d a=%h b=%h rd=%0d -> res=%h lat=%0d", f3, a, b, rd, oResult, lat);
        @(negedge iClk);
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse f3=%0d: got %b expected 0", f3, oValid);
        end
    endtask

    task automatic test_reset();
        iRstN = 1'b0; iStart = 1'b0; iFlush = 1'b0; iFunct3 = '0; iRs1 = '0; iRs2 = '0; iRd = '0;
        repeat (3) @(negedge iClk);
        checks++;
        if ({oBusy, oValid, oResult, oRd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b res=%h rd=%0d expected all 0",
                     oBusy, oValid, oResult, oRd);
        end
        iRstN = 1'b1;
        $display("reset released");
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7);
    endtask

    task automatic test_special_div();
        run_op(3'd5, 32'd5, 32'd0, 5'd8);
        run_op(3'd7, 32'd5, 32'd0, 5'd9);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd12);
    endtask

    task automatic test_flush();
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        prev_res = oResult;
        prev_rd  = oRd;
        @(negedge iClk);
        iStart = 1'b1; iFunct3 = 3'd0; iRs1 = 32'd100; iRs2 = 32'd200; iRd = 5'd20;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (11) @(negedge iClk);     // counter is 10 during this cycle
        iFlush = 1'b1;
        @(negedge iClk);
        iFlush = 1'b0;
        checks++;
        if (oBusy !== 1'b0 || oValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got busy=%b valid=%b expected 0 0", oBusy, oValid);
        end
        checks++;
        if (oResult !== prev_res || oRd !== prev_rd) begin
            errors++;
            $display("FAIL flush_hold: got res=%h rd=%0d expected %h %0d", oResult, oRd, prev_res, prev_rd);
        end
        $display("flush at counter 10 -> busy=%b res=%h", oBusy, oResult);
        run_op(3'd0, 32'd3, 32'd4, 5'd21);
        // Start together with flush in IDLE must be ignored.
        @(negedge iClk);
        iStart = 1'b1; iFlush = 1'b1; iFunct3 = 3'd0;
        @(negedge iClk);
        iStart = 1'b0; iFlush = 1'b0;
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_idle: got busy=%b expected 0", oBusy);
        end
        $display("start+flush in idle -> busy=%b", oBusy);
    endtask

    task automatic test_start_while_busy();
        int valids;
        logic [31:0] exp_res;
        exp_res = ref_result(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge iClk);
        iStart = 1'b1; iFunct3 = 3'd1; iRs1 = 32'h1234_5678; iRs2 = 32'h9ABC_DEF0; iRd = 5'd15;
        @(negedge iClk);
        iStart = 1'b0;
        valids = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge iClk);
            if (oValid) begin
                valids++;
                checks++;
                if (oResult !== exp_res) begin
                    errors++;
                    $display("FAIL busy_start_result: got %h expected %h", oResult, exp_res);
                end
            end
            iStart = (k == 5 || k == 20) ? 1'b1 : 1'b0;
            iFunct3 = 3'd0; iRs1 = 32'd9; iRs2 = 32'd9;
        end
        iStart = 1'b0;
        checks++;
        if (valids !== 1) begin
            errors++;
            $display("FAIL busy_start_valids: got %0d expected 1", valids);
        end
        $display("start pulses while busy -> valid pulses=%0d", valids);
    endtask

    task automatic test_reset_mid_op();
        @(negedge iClk);
        iStart = 1'b1; iFunct3 = 3'd5; iRs1 = 32'hDEAD_BEEF; iRs2 = 32'd3; iRd = 5'd30;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (15) @(negedge iClk);
        iRstN = 1'b0; iStart = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge iClk);
            checks++;
            if ({oBusy, oValid, oResult, oRd} !== '0) begin
                errors++;
                $display("FAIL reset_mid_op cycle %0d: got busy=%b valid=%b res=%h rd=%0d expected all 0",
                         k, oBusy, oValid, oResult, oRd);
            end
        end
        iRstN = 1'b1; iStart = 1'b0;
        @(negedge iClk);
        checks++;
        if (oBusy !== 1'b0 || oValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b valid=%b expected 0 0", oBusy, oValid);
        end
        $display("reset mid-op -> busy=%b res=%h", oBusy, oResult);
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd31);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = -32'($urandom_range(1, 1000));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(f3, a, b, 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special_div();
        test_flush();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
